lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//   Multi-cycle load/store sequencer between the execute stage and the data bus.
//   Consumes decoder outputs mem_read/mem_write/mem_size/mem_unsigned plus ALU address.
//   Drives a req/ack data bus with byte enables, stalls the core while an access is in
//   flight, and returns aligned, sign/zero-extended load data.
//   Flags misaligned, illegal and timed-out accesses.
// PARAMETERS
//   TIMEOUT  255  max BUS-state cycles without bus_ack before a timeout fault (>=1)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_valid    in   1   execute stage holds a memory op; held stable while stall=1
//   mem_read     in   1   load request
//   mem_write    in   1   store request
//   mem_size     in   2   00=byte 01=half 10=word 11=illegal
//   mem_unsigned in   1   zero-extend load (lbu/lhu)
//   addr         in   32  byte address
//   wdata        in   32  store data, LSBs significant
//   stall        out  1   freeze PC/pipeline this cycle
//   done         out  1   one-cycle pulse: access retired (pipeline advances this cycle)
//   rdata_out    out  32  extended load result; valid with done, held until next load done
//   fault        out  1   with done: access aborted
//   fault_code   out  2   01=misaligned 10=timeout 11=illegal; 00 when fault=0
//   bus_req      out  1   bus request, held until bus_ack
//   bus_we       out  1   1=write
//   bus_addr     out  32  {addr[31:2],2'b00}
//   bus_be       out  4   byte enables
//   bus_wdata    out  32  lane-replicated store data
//   bus_ack      in   1   bus completes access this cycle
//   bus_rdata    in   32  read word, valid with bus_ack
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; timeout counter 0. Takes effect mid-access:
//     bus_req drops immediately, no done pulse.
//   FSM: IDLE, BUS, DONE, FAULT.
//   IDLE: launch = req_valid & (mem_read|mem_write). No launch -> stay, stall=0.
//     On launch, stall=1 and the request (op, size, unsigned, addr[1:0], wdata) is latched.
//     Illegal (size=11 or read&write) -> FAULT, code 11.
//     Misaligned (half & addr[0], word & addr[1:0]!=0) -> FAULT, code 01; no bus cycle.
//     Otherwise -> BUS, counter cleared.
//   BUS: bus_req=1; addr/we/be/wdata stable from the latch; stall=1.
//     bus_ack -> capture load data, go DONE.
//     No ack -> counter++; at counter==TIMEOUT-1 without ack -> FAULT, code 10.
//       Ack in the same cycle wins.
//   DONE: done=1, stall=0, bus_req=0, then IDLE; req_valid this cycle does not relaunch.
//   FAULT: done=1, fault=1, fault_code valid, stall=0, then IDLE; rdata_out unchanged.
//   Latency: ack in first BUS cycle -> done 2 cycles after launch. No-launch ops never stall.
//   Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//   Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//   Load: sh = bus_rdata >> (8*addr[1:0]).
//     Byte/half take sh[7:0]/sh[15:0], sign-extended unless mem_unsigned.
//     Word passes unchanged. mem_unsigned is ignored for word.
//   Store done leaves rdata_out unchanged. bus_ack outside BUS is ignored.
// STRUCTURE
//   Shared package cpu_pkg: MEM_B/MEM_H/MEM_W size codes, FAULT_* codes,
//     lsu_state_t FSM encoding.
//   Sub-module lsu_align (combinational): bus_be, lane replication, load shift/extend.
//     The FSM, latch and counter stay in lsu_ctrl.
// TESTING
//   lw addr=0x100, ack 3 cycles after launch, rdata=0xDEADBEEF
//     -> bus_be=1111, stall 4 cycles, done with rdata_out=0xDEADBEEF.
//   lb addr=0x103, rdata=0x80xxxxxx -> bus_addr=0x100, be=1000, rdata_out=0xFFFFFF80.
//     Same with lbu -> 0x00000080.
//   sh addr=0x102 wdata=0x1234ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD;
//     rdata_out unchanged.
//   lw addr=0x101 -> no bus_req, done+fault, code 01 the cycle after launch.
//     size=11 -> code 11.
//   TIMEOUT=4, no ack -> bus_req for 4 cycles then FAULT code 10.
//     Ack on 4th cycle -> normal done.
//   rst_n low during BUS -> bus_req=0 same cycle, no done. After release, new lw completes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the load/store unit: access sizes, fault codes, sequencer states.
package cpu_pkg;

  localparam logic [1:0] MEM_B   = 2'b00;
  localparam logic [1:0] MEM_H   = 2'b01;
  localparam logic [1:0] MEM_W   = 2'b10;
  localparam logic [1:0] MEM_ILL = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUS   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } lsu_state_t;

  // A half needs an even address, a word needs a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      MEM_H:   mis = off[0];
      MEM_W:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-bus side of the load/store unit: req/ack handshake, address, byte enables, data.
interface lsu_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// Lane steering for the data bus: byte enables, store replication, load shift and extend.
module lsu_ctrl_align
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] sh_s;

  // Shift the addressed lane down to bit 0; word accesses are aligned so the shift is zero.
  always_comb begin
    sh_s      = bus_rdata >> {byte_off, 3'b000};
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    load_data = 32'h0000_0000;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << byte_off;
        wdata_rep = {4{wdata[7:0]}};
        load_data = is_unsigned ? {24'h00_0000, sh_s[7:0]} : {{24{sh_s[7]}}, sh_s[7:0]};
      end
      MEM_H: begin
        be        = 4'b0011 << byte_off;
        wdata_rep = {2{wdata[15:0]}};
        load_data = is_unsigned ? {16'h0000, sh_s[15:0]} : {{16{sh_s[15]}}, sh_s[15:0]};
      end
      MEM_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_data = sh_s;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        load_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer: latches an execute-stage memory op, runs one bus
// transaction, stalls the core meanwhile, and retires with extended data or a fault.
module lsu_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic              fault,
  output logic [1:0]        fault_code,
  lsu_ctrl_if.master        bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state_r, state_nxt_s;
  logic              read_r, we_r, unsigned_r;
  logic [1:0]        size_r, fault_code_r;
  logic [31:0]       addr_r, wdata_r, rdata_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              launch_s, illegal_s, misaligned_s, timeout_s, stall_s, in_bus_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_rep_s, load_data_s;

  assign launch_s     = req_valid & (mem_read | mem_write);
  assign illegal_s    = (mem_size == MEM_ILL) | (mem_read & mem_write);
  assign misaligned_s = is_misaligned(mem_size, addr[1:0]);
  assign timeout_s    = (cnt_r == CNT_W'(TIMEOUT - 1));
  assign in_bus_s     = (state_r == ST_BUS);

  lsu_ctrl_align u_align (
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .byte_off    (addr_r[1:0]),
    .wdata       (wdata_r),
    .bus_rdata   (bus.bus_rdata),
    .be          (be_s),
    .wdata_rep   (wdata_rep_s),
    .load_data   (load_data_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and stall; an ack in the last allowed BUS cycle beats the timeout.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          stall_s = 1'b1;
          if (illegal_s || misaligned_s) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_BUS;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        stall_s = 1'b1;
        if (bus.bus_ack) begin
          state_nxt_s = ST_DONE;
        end else if (timeout_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_BUS;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      ST_FAULT: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, fault code and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_r       <= 1'b0;
      we_r         <= 1'b0;
      unsigned_r   <= 1'b0;
      size_r       <= 2'b00;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      cnt_r        <= '0;
      fault_code_r <= FAULT_NONE;
      rdata_r      <= 32'h0000_0000;
    end else if (state_r == ST_IDLE && launch_s) begin
      read_r       <= mem_read;
      we_r         <= mem_write;
      unsigned_r   <= mem_unsigned;
      size_r       <= mem_size;
      addr_r       <= addr;
      wdata_r      <= wdata;
      cnt_r        <= '0;
      fault_code_r <= illegal_s ? FAULT_ILLEGAL : (misaligned_s ? FAULT_MISALIGN : FAULT_NONE);
    end else if (in_bus_s) begin
      if (bus.bus_ack) begin
        if (read_r) begin
          rdata_r <= load_data_s;
        end
      end else if (timeout_s) begin
        fault_code_r <= FAULT_TIMEOUT;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall      = stall_s;
  assign done       = (state_r == ST_DONE) || (state_r == ST_FAULT);
  assign fault      = (state_r == ST_FAULT);
  assign fault_code = fault ? fault_code_r : FAULT_NONE;
  assign rdata_out  = rdata_r;

  // Bus fields are only driven while a transaction is outstanding.
  assign bus.bus_req   = in_bus_s;
  assign bus.bus_we    = in_bus_s & we_r;
  assign bus.bus_addr  = in_bus_s ? {addr_r[31:2], 2'b00} : 32'h0000_0000;
  assign bus.bus_be    = in_bus_s ? be_s : 4'b0000;
  assign bus.bus_wdata = in_bus_s ? wdata_rep_s : 32'h0000_0000;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 4-cycle bus timeout.
module tb_lsu_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata_out;
  logic [1:0]  fault_code;

  int checks = 0;
  int failures = 0;

  int          o_stall, o_done_at, o_req;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic        o_we, o_fault, o_post_req, o_post_done, o_post_stall;
  logic [1:0]  o_code;

  lsu_ctrl_if bus_if ();

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .done         (done),
    .rdata_out    (rdata_out),
    .fault        (fault),
    .fault_code   (fault_code),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  // Runs one access; ack_at is the cycle (0 = launch cycle) in which bus_ack is raised, -1 = never.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                           input logic [31:0] rdat);
    int cyc;
    bit fin;
    cyc = 0; fin = 1'b0;
    o_stall = 0; o_req = 0; o_done_at = -1;
    o_be = 4'h0; o_addr = 32'h0; o_wdata = 32'h0; o_we = 1'b0;
    o_rdata = 32'h0; o_fault = 1'b0; o_code = 2'b00;
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = uns; addr = a; wdata = wd;
    while (!fin && cyc < 30) begin
      if (cyc > 0) @(negedge clk);
      bus_if.bus_ack   = (cyc == ack_at);
      bus_if.bus_rdata = (cyc == ack_at) ? rdat : 32'h5A5A_5A5A;
      #1;
      if (stall) o_stall++;
      if (bus_if.bus_req) begin
        o_req++;
        o_be = bus_if.bus_be; o_addr = bus_if.bus_addr;
        o_wdata = bus_if.bus_wdata; o_we = bus_if.bus_we;
      end
      if (done) begin
        fin = 1'b1; o_done_at = cyc;
        o_rdata = rdata_out; o_fault = fault; o_code = fault_code;
      end
      cyc++;
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL access_bound: no done within %0d cycles (addr=%h)", cyc, a);
    end
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_if.bus_ack = 1'b0;
    #1;
    o_post_req = bus_if.bus_req; o_post_done = done; o_post_stall = stall;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00;
    mem_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stall, done, fault, fault_code} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b want 00000", {stall, done, fault, fault_code});
    end
    checks++;
    if (rdata_out !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h want 00000000", rdata_out);
    end
    checks++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata} !== 70'h0) begin
      failures++; $display("FAIL reset_bus: req=%b be=%b addr=%h want all 0",
                           bus_if.bus_req, bus_if.bus_be, bus_if.bus_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw;
    do_access(1'b1, 1'b0, MEM_W, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    checks++;
    if (o_be !== 4'b1111 || o_addr !== 32'h100 || o_we !== 1'b0) begin
      failures++; $display("FAIL lw_bus: be=%b addr=%h we=%b want 1111 00000100 0", o_be, o_addr, o_we);
    end
    checks++;
    if (o_stall != 4 || o_done_at != 4 || o_req != 3) begin
      failures++; $display("FAIL lw_timing: stall=%0d done_at=%0d req=%0d want 4 4 3", o_stall, o_done_at, o_req);
    end
    checks++;
    if (o_rdata !== 32'hDEAD_BEEF || o_fault !== 1'b0) begin
      failures++; $display("FAIL lw_data: rdata=%h fault=%b want deadbeef 0", o_rdata, o_fault);
    end
    checks++;
    if (o_post_req !== 1'b0 || o_post_done !== 1'b0 || o_post_stall !== 1'b0) begin
      failures++; $display("FAIL lw_no_relaunch: req=%b done=%b stall=%b want 0 0 0",
                           o_post_req, o_post_done, o_post_stall);
    end
  endtask

  task automatic test_loads;
    do_access(1'b1, 1'b0, MEM_B, 1'b0, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
    checks++;
    if (o_addr !== 32'h100 || o_be !== 4'b1000 || o_done_at != 2) begin
      failures++; $display("FAIL lb_bus: addr=%h be=%b done_at=%0d want 00000100 1000 2", o_addr, o_be, o_done_at);
    end
    checks++;
    if (o_rdata !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL lb_ext: got %h want ffffff80", o_rdata);
    end
    do_access(1'b1, 1'b0, MEM_B, 1'b1, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
    checks++;
    if (o_rdata !== 32'h0000_0080) begin
      failures++; $display("FAIL lbu_ext: got %h want 00000080", o_rdata);
    end
    do_access(1'b1, 1'b0, MEM_H, 1'b0, 32'h0000_0102, 32'h0, 2, 32'h8001_7777);
    checks++;
    if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF_8001) begin
      failures++; $display("FAIL lh_ext: be=%b rdata=%h want 1100 ffff8001", o_be, o_rdata);
    end
  endtask

  task automatic test_stores;
    do_access(1'b0, 1'b1, MEM_H, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 1, 32'h0);
    checks++;
    if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD) begin
      failures++; $display("FAIL sh_bus: we=%b be=%b wdata=%h want 1 1100 abcdabcd", o_we, o_be, o_wdata);
    end
    checks++;
    if (o_rdata !== 32'hFFFF_8001 || o_fault !== 1'b0) begin
      failures++; $display("FAIL sh_rdata_kept: rdata=%h fault=%b want ffff8001 0", o_rdata, o_fault);
    end
    do_access(1'b0, 1'b1, MEM_B, 1'b0, 32'h0000_0101, 32'h0000_00EF, 1, 32'h0);
    checks++;
    if (o_be !== 4'b0010 || o_wdata !== 32'hEFEF_EFEF) begin
      failures++; $display("FAIL sb_bus: be=%b wdata=%h want 0010 efefefef", o_be, o_wdata);
    end
  endtask

  task automatic test_faults;
    do_access(1'b1, 1'b0, MEM_W, 1'b0, 32'h0000_0101, 32'h0, -1, 32'h0);
    checks++;
    if (o_req != 0 || o_done_at != 1 || o_fault !== 1'b1 || o_code !== FAULT_MISALIGN) begin
      failures++; $display("FAIL lw_misalign: req=%0d done_at=%0d fault=%b code=%b want 0 1 1 01",
                           o_req, o_done_at, o_fault, o_code);
    end
    checks++;
    if (o_rdata !== 32'hFFFF_8001) begin
      failures++; $display("FAIL fault_rdata_kept: got %h want ffff8001", o_rdata);
    end
    do_access(1'b1, 1'b0, MEM_H, 1'b0, 32'h0000_0203, 32'h0, -1, 32'h0);
    checks++;
    if (o_req != 0 || o_code !== FAULT_MISALIGN) begin
      failures++; $display("FAIL lh_misalign: req=%0d code=%b want 0 01", o_req, o_code);
    end
    do_access(1'b1, 1'b0, MEM_ILL, 1'b0, 32'h0000_0100, 32'h0, -1, 32'h0);
    checks++;
    if (o_req != 0 || o_done_at != 1 || o_code !== FAULT_ILLEGAL) begin
      failures++; $display("FAIL size_illegal: req=%0d done_at=%0d code=%b want 0 1 11", o_req, o_done_at, o_code);
    end
    do_access(1'b1, 1'b1, MEM_W, 1'b0, 32'h0000_0100, 32'h0, -1, 32'h0);
    checks++;
    if (o_req != 0 || o_code !== FAULT_ILLEGAL) begin
      failures++; $display("FAIL rw_illegal: req=%0d code=%b want 0 11", o_req, o_code);
    end
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, MEM_W, 1'b0, 32'h0000_0200, 32'h0, -1, 32'h0);
    checks++;
    if (o_req != 4 || o_done_at != 5 || o_fault !== 1'b1 || o_code !== FAULT_TIMEOUT) begin
      failures++; $display("FAIL timeout: req=%0d done_at=%0d fault=%b code=%b want 4 5 1 10",
                           o_req, o_done_at, o_fault, o_code);
    end
    do_access(1'b1, 1'b0, MEM_W, 1'b0, 32'h0000_0200, 32'h0, 4, 32'hCAFE_F00D);
    checks++;
    if (o_done_at != 5 || o_fault !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL ack_last_cycle: done_at=%0d fault=%b rdata=%h want 5 0 cafef00d",
                           o_done_at, o_fault, o_rdata);
    end
  endtask

  task automatic test_no_launch;
    int bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_size = MEM_W; addr = 32'h100;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall || bus_if.bus_req || done) bad++;
      @(negedge clk);
    end
    req_valid = 1'b0; mem_read = 1'b1;
    #1;
    if (stall || bus_if.bus_req || done) bad++;
    @(negedge clk);
    mem_read = 1'b0; bus_if.bus_ack = 1'b0;
    #1;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL no_launch: %0d cycles with stall/req/done set, want 0", bad);
    end
    checks++;
    if (rdata_out !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL stray_ack: rdata=%h want cafef00d", rdata_out);
    end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = MEM_W; addr = 32'h300;
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.bus_req !== 1'b1) begin
      failures++; $display("FAIL mid_reset_pre: bus_req=%b want 1", bus_if.bus_req);
    end
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
    #1;
    checks++;
    if (bus_if.bus_req !== 1'b0 || done !== 1'b0 || rdata_out !== 32'h0) begin
      failures++; $display("FAIL mid_reset: req=%b done=%b rdata=%h want 0 0 00000000",
                           bus_if.bus_req, done, rdata_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done || bus_if.bus_req) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      failures++; $display("FAIL post_reset_idle: %0d cycles with done/req, want 0", seen_done);
    end
    do_access(1'b1, 1'b0, MEM_W, 1'b0, 32'h0000_0400, 32'h0, 1, 32'h1357_9BDF);
    checks++;
    if (o_done_at != 2 || o_rdata !== 32'h1357_9BDF || o_fault !== 1'b0) begin
      failures++; $display("FAIL post_reset_lw: done_at=%0d rdata=%h fault=%b want 2 13579bdf 0",
                           o_done_at, o_rdata, o_fault);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_no_launch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
